// File: rtl/module_uart_host_ctrl_pkg.sv
// Shared types and register-map constants for the UART host controller.
package pkg_UART;

  typedef enum logic [2:0] {
    IDLE,
    TX_WR_DATA,
    TX_WR_CTRL,
    TX_WAIT,
    RX_RD_DATA,
    RX_CLR_CTRL
  } state_e;

  localparam int unsigned SEND   = 0;
  localparam int unsigned NEW_RX = 1;

  localparam logic REG_SEL_CONTROL = 1'b0;
  localparam logic REG_SEL_DATA    = 1'b1;

  localparam logic ADDR_TX = 1'b0;
  localparam logic ADDR_RX = 1'b1;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/module_uart_host_ctrl_timeout.sv
// Cycle counter for the TX completion wait; flags the last permitted cycle.
module module_timeout_counter
  import pkg_UART::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CW = cnt_width(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Holding at the terminal value keeps the count from ever wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/module_uart_host_ctrl.sv
// Host-side controller that moves TX/RX bytes through a two-register UART
// peripheral (control + data), polling the control register while idle.
module module_uart_host_ctrl
  import pkg_UART::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  tx_data_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  output logic        tx_done_o,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic        err_o,
  output logic        wr_o,
  output logic        reg_sel_o,
  output logic        addr_o,
  output logic [31:0] data_o,
  input  logic [31:0] data_i
);

  state_e      state_q;
  logic        wr_q;
  logic        reg_sel_q;
  logic        addr_q;
  logic [31:0] data_q;
  logic        tx_done_q;
  logic        rx_valid_q;
  logic [7:0]  rx_data_q;
  logic        err_q;

  logic        rx_take;
  logic        tx_accept;
  logic        tmo_tc;
  logic        unused_data;

  // A held RX byte blocks servicing NEW_RX so the peripheral keeps the next one.
  assign rx_take     = data_i[NEW_RX] && !rx_valid_q;
  assign tx_ready_o  = (state_q == IDLE) && !rx_take && !rst_i;
  assign tx_accept   = tx_valid_i && tx_ready_o;
  assign unused_data = ^data_i[31:8];

  module_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .clr_i(state_q == TX_WR_CTRL),
    .en_i (state_q == TX_WAIT),
    .tc_o (tmo_tc)
  );

  // Bus outputs are registered for the state being entered; default is an idle control read.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      wr_q       <= 1'b0;
      reg_sel_q  <= REG_SEL_CONTROL;
      addr_q     <= ADDR_TX;
      data_q     <= '0;
      tx_done_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      wr_q      <= 1'b0;
      reg_sel_q <= REG_SEL_CONTROL;
      addr_q    <= ADDR_TX;
      data_q    <= '0;
      tx_done_q <= 1'b0;
      if (rx_valid_q && rx_ready_i) begin
        rx_valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (rx_take) begin
            state_q   <= RX_RD_DATA;
            reg_sel_q <= REG_SEL_DATA;
            addr_q    <= ADDR_RX;
          end else if (tx_accept) begin
            state_q   <= TX_WR_DATA;
            wr_q      <= 1'b1;
            reg_sel_q <= REG_SEL_DATA;
            addr_q    <= ADDR_TX;
            data_q    <= {24'h0, tx_data_i};
          end
        end
        TX_WR_DATA: begin
          state_q <= TX_WR_CTRL;
          wr_q    <= 1'b1;
          data_q  <= 32'h1;
        end
        TX_WR_CTRL: state_q <= TX_WAIT;
        TX_WAIT: begin
          if (!data_i[SEND]) begin
            state_q   <= IDLE;
            tx_done_q <= 1'b1;
          end else if (tmo_tc) begin
            state_q <= IDLE;
            err_q   <= 1'b1;
          end
        end
        RX_RD_DATA: begin
          rx_data_q  <= data_i[7:0];
          rx_valid_q <= 1'b1;
          state_q    <= RX_CLR_CTRL;
          wr_q       <= 1'b1;
        end
        RX_CLR_CTRL: state_q <= IDLE;
        default:     state_q <= IDLE;
      endcase
    end
  end

  assign wr_o       = wr_q;
  assign reg_sel_o  = reg_sel_q;
  assign addr_o     = addr_q;
  assign data_o     = data_q;
  assign tx_done_o  = tx_done_q;
  assign rx_valid_o = rx_valid_q;
  assign rx_data_o  = rx_data_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_module_uart_host_ctrl.sv
// Bench for the UART host controller: peripheral register model, bus-event
// scoreboard, and a second instance with a short timeout that never sees SEND clear.
module tb_module_uart_host_ctrl;

  typedef struct packed {
    logic [31:0] cyc;
    logic [1:0]  kind;
    logic        wr;
    logic        sel;
    logic        addr;
    logic [31:0] data;
  } ev_t;

  localparam logic [1:0] K_BUS  = 2'd0;
  localparam logic [1:0] K_DONE = 2'd1;
  localparam int SEND_LAT = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  tx_data = 8'h0;
  logic        tx_valid = 1'b0;
  logic        rx_ready = 1'b0;
  logic        tx_ready_o, tx_done_o, rx_valid_o, err_o, wr_o, reg_sel_o, addr_o;
  logic [7:0]  rx_data_o;
  logic [31:0] data_o, data_i;

  logic [7:0]  tx_data2 = 8'h0;
  logic        tx_valid2 = 1'b0;
  logic        rx_ready2 = 1'b0;
  logic [31:0] data2_i = 32'h1;
  logic        ready2, done2, rxv2, err2, wr2, sel2, addr2;
  logic [7:0]  rxd2;
  logic [31:0] data2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Peripheral register model
  logic        ctrl_send = 1'b0;
  logic        ctrl_newrx = 1'b0;
  logic [7:0]  tx_reg = 8'h0;
  logic [7:0]  rx_reg = 8'h0;
  int          send_clr_cyc = 0;
  bit          never_clear = 1'b0;
  int          rx_tok = 0;
  int          rx_seen = 0;
  logic [7:0]  rx_byte_m = 8'h0;

  ev_t obs [0:511];
  int  obs_n = 0;
  int  viol = 0;
  int  rd = 0;
  ev_t exp_q [$];

  always #5 clk = ~clk;

  module_uart_host_ctrl dut (
    .clk_i(clk), .rst_i(rst), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
    .tx_ready_o(tx_ready_o), .tx_done_o(tx_done_o), .rx_data_o(rx_data_o),
    .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready), .err_o(err_o), .wr_o(wr_o),
    .reg_sel_o(reg_sel_o), .addr_o(addr_o), .data_o(data_o), .data_i(data_i)
  );

  module_uart_host_ctrl #(.TIMEOUT_CYCLES(16)) dut_tmo (
    .clk_i(clk), .rst_i(rst), .tx_data_i(tx_data2), .tx_valid_i(tx_valid2),
    .tx_ready_o(ready2), .tx_done_o(done2), .rx_data_o(rxd2),
    .rx_valid_o(rxv2), .rx_ready_i(rx_ready2), .err_o(err2), .wr_o(wr2),
    .reg_sel_o(sel2), .addr_o(addr2), .data_o(data2), .data_i(data2_i)
  );

  assign data_i = reg_sel_o ? (addr_o ? {24'h0, rx_reg} : {24'h0, tx_reg})
                            : {30'h0, ctrl_newrx, ctrl_send};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (wr_o && reg_sel_o && !addr_o) tx_reg <= data_o[7:0];
    if (wr_o && !reg_sel_o) begin
      ctrl_send  <= data_o[0];
      ctrl_newrx <= data_o[1];
      if (data_o[0]) send_clr_cyc <= cyc + SEND_LAT - 2;
    end else if (ctrl_send && !never_clear && cyc == send_clr_cyc) begin
      ctrl_send <= 1'b0;
    end
    if (rx_tok != rx_seen) begin
      rx_seen    <= rx_tok;
      ctrl_newrx <= 1'b1;
      rx_reg     <= rx_byte_m;
    end
  end

  // Bus monitor: logs every non-idle access and every tx_done pulse
  always begin
    @(negedge clk);
    #2;
    if ((wr_o || reg_sel_o) && obs_n < 512) begin
      obs[obs_n] = {32'(cyc), K_BUS, wr_o, reg_sel_o, addr_o, data_o};
      obs_n++;
    end
    if (tx_done_o && obs_n < 512) begin
      obs[obs_n] = {32'(cyc), K_DONE, 1'b0, 1'b0, 1'b0, 32'h0};
      obs_n++;
    end
    if ((!wr_o && data_o != 32'h0) || (tx_ready_o && (wr_o || reg_sel_o))) viol++;
  end

  function automatic ev_t mk(input int c, input logic [1:0] k, input logic w,
                             input logic s, input logic a, input logic [31:0] d);
    return {32'(c), k, w, s, a, d};
  endfunction

  task automatic wait_obs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (obs_n > rd) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      #3;
    end
  endtask

  task automatic handshake(input logic [7:0] b, output int n);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    n = -1;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (tx_ready_o) begin
        n = cyc;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({wr_o, reg_sel_o, addr_o, data_o, tx_done_o, rx_valid_o, rx_data_o, err_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got wr=%b sel=%b addr=%b data=%h done=%b rxv=%b rxd=%h err=%b, required all 0",
               wr_o, reg_sel_o, addr_o, data_o, tx_done_o, rx_valid_o, rx_data_o, err_o);
    end
    checks++;
    if (tx_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %b required 0", tx_ready_o);
    end
    checks++;
    if (err2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_err_tmo: got %b required 0", err2);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (tx_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b required 1", tx_ready_o);
    end
  endtask

  task automatic test_tx();
    int n;
    ev_t e, o;
    bit ok;
    handshake(8'hA5, n);
    checks++;
    if (n < 0) begin
      errors++;
      $display("FAIL tx_handshake: got no tx_ready required handshake");
    end
    exp_q.push_back(mk(n + 1, K_BUS, 1'b1, 1'b1, 1'b0, 32'h0000_00A5));
    exp_q.push_back(mk(n + 2, K_BUS, 1'b1, 1'b0, 1'b0, 32'h1));
    exp_q.push_back(mk(n + 2 + SEND_LAT, K_DONE, 1'b0, 1'b0, 1'b0, 32'h0));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      wait_obs(ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL tx_event: got nothing, required cyc=%0d kind=%0d data=%h", e.cyc, e.kind, e.data);
      end else begin
        o = obs[rd];
        rd++;
        if (o !== e) begin
          errors++;
          $display("FAIL tx_event: got cyc=%0d kind=%0d wr=%b sel=%b addr=%b data=%h, required cyc=%0d kind=%0d wr=%b sel=%b addr=%b data=%h",
                   o.cyc, o.kind, o.wr, o.sel, o.addr, o.data, e.cyc, e.kind, e.wr, e.sel, e.addr, e.data);
        end
      end
    end
    repeat (5) @(negedge clk);
    #3;
    checks++;
    if (obs_n !== rd) begin
      errors++;
      $display("FAIL tx_single_done: got %0d extra events required 0", obs_n - rd);
      rd = obs_n;
    end
  endtask

  task automatic test_rx();
    int k;
    ev_t e, o;
    bit ok;
    @(negedge clk);
    k = cyc;
    rx_byte_m = 8'h3C;
    rx_tok++;
    exp_q.push_back(mk(k + 2, K_BUS, 1'b0, 1'b1, 1'b1, 32'h0));
    exp_q.push_back(mk(k + 3, K_BUS, 1'b1, 1'b0, 1'b0, 32'h0));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      wait_obs(ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL rx_event: got nothing, required cyc=%0d kind=%0d data=%h", e.cyc, e.kind, e.data);
      end else begin
        o = obs[rd];
        rd++;
        if (o !== e) begin
          errors++;
          $display("FAIL rx_event: got cyc=%0d wr=%b sel=%b addr=%b data=%h, required cyc=%0d wr=%b sel=%b addr=%b data=%h",
                   o.cyc, o.wr, o.sel, o.addr, o.data, e.cyc, e.wr, e.sel, e.addr, e.data);
        end
      end
    end
    for (int i = 0; i < 20 && rx_valid_o !== 1'b1; i++) @(negedge clk);
    checks++;
    if (rx_valid_o !== 1'b1 || rx_data_o !== 8'h3C) begin
      errors++;
      $display("FAIL rx_data: got valid=%b data=%h required valid=1 data=3c", rx_valid_o, rx_data_o);
    end
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    #1;
    checks++;
    if (rx_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL rx_consume: got valid=%b required 0", rx_valid_o);
    end
  endtask

  task automatic test_rx_backpressure();
    int k, m;
    ev_t e, o;
    bit ok;
    @(negedge clk);
    k = cyc;
    rx_byte_m = 8'h11;
    rx_tok++;
    exp_q.push_back(mk(k + 2, K_BUS, 1'b0, 1'b1, 1'b1, 32'h0));
    exp_q.push_back(mk(k + 3, K_BUS, 1'b1, 1'b0, 1'b0, 32'h0));
    for (int i = 0; i < 8; i++) @(negedge clk);
    @(negedge clk);
    rx_byte_m = 8'h22;
    rx_tok++;
    repeat (20) @(negedge clk);
    #3;
    m = 0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      wait_obs(ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL bp_first_event: got nothing, required cyc=%0d", e.cyc);
      end else begin
        o = obs[rd];
        rd++;
        if (o !== e) begin
          errors++;
          $display("FAIL bp_first_event: got cyc=%0d wr=%b sel=%b addr=%b data=%h, required cyc=%0d wr=%b sel=%b addr=%b data=%h",
                   o.cyc, o.wr, o.sel, o.addr, o.data, e.cyc, e.wr, e.sel, e.addr, e.data);
        end
      end
    end
    checks++;
    if (obs_n !== rd) begin
      errors++;
      $display("FAIL bp_no_read: got %0d bus events while held, required 0", obs_n - rd);
      rd = obs_n;
    end
    checks++;
    if (rx_valid_o !== 1'b1 || rx_data_o !== 8'h11) begin
      errors++;
      $display("FAIL bp_hold: got valid=%b data=%h required valid=1 data=11", rx_valid_o, rx_data_o);
    end
    @(negedge clk);
    m = cyc;
    rx_ready = 1'b1;
    exp_q.push_back(mk(m + 2, K_BUS, 1'b0, 1'b1, 1'b1, 32'h0));
    exp_q.push_back(mk(m + 3, K_BUS, 1'b1, 1'b0, 1'b0, 32'h0));
    @(negedge clk);
    rx_ready = 1'b0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      wait_obs(ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL bp_second_event: got nothing, required cyc=%0d", e.cyc);
      end else begin
        o = obs[rd];
        rd++;
        if (o !== e) begin
          errors++;
          $display("FAIL bp_second_event: got cyc=%0d wr=%b sel=%b addr=%b data=%h, required cyc=%0d wr=%b sel=%b addr=%b data=%h",
                   o.cyc, o.wr, o.sel, o.addr, o.data, e.cyc, e.wr, e.sel, e.addr, e.data);
        end
      end
    end
    for (int i = 0; i < 20 && rx_valid_o !== 1'b1; i++) @(negedge clk);
    checks++;
    if (rx_valid_o !== 1'b1 || rx_data_o !== 8'h22) begin
      errors++;
      $display("FAIL bp_second_data: got valid=%b data=%h required valid=1 data=22", rx_valid_o, rx_data_o);
    end
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic test_simultaneous();
    int k;
    ev_t e, o;
    bit ok;
    @(negedge clk);
    k = cyc;
    rx_byte_m = 8'h77;
    rx_tok++;
    @(negedge clk);
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      #1;
      checks++;
      if (tx_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL sim_ready_low: got %b at cycle k+%0d required 0", tx_ready_o, i);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (tx_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL sim_ready_high: got %b at cycle k+4 required 1", tx_ready_o);
    end
    @(negedge clk);
    tx_valid = 1'b0;
    exp_q.push_back(mk(k + 2, K_BUS, 1'b0, 1'b1, 1'b1, 32'h0));
    exp_q.push_back(mk(k + 3, K_BUS, 1'b1, 1'b0, 1'b0, 32'h0));
    exp_q.push_back(mk(k + 5, K_BUS, 1'b1, 1'b1, 1'b0, 32'h0000_00C3));
    exp_q.push_back(mk(k + 6, K_BUS, 1'b1, 1'b0, 1'b0, 32'h1));
    exp_q.push_back(mk(k + 6 + SEND_LAT, K_DONE, 1'b0, 1'b0, 1'b0, 32'h0));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      wait_obs(ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL sim_event: got nothing, required cyc=%0d kind=%0d", e.cyc, e.kind);
      end else begin
        o = obs[rd];
        rd++;
        if (o !== e) begin
          errors++;
          $display("FAIL sim_event: got cyc=%0d kind=%0d wr=%b sel=%b addr=%b data=%h, required cyc=%0d kind=%0d wr=%b sel=%b addr=%b data=%h",
                   o.cyc, o.kind, o.wr, o.sel, o.addr, o.data, e.cyc, e.kind, e.wr, e.sel, e.addr, e.data);
        end
      end
    end
    checks++;
    if (rx_valid_o !== 1'b1 || rx_data_o !== 8'h77 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL sim_rx_state: got valid=%b data=%h err=%b required valid=1 data=77 err=0", rx_valid_o, rx_data_o, err_o);
    end
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic test_reset_mid_tx();
    int n;
    ev_t e, o;
    bit ok;
    never_clear = 1'b1;
    handshake(8'h5A, n);
    exp_q.push_back(mk(n + 1, K_BUS, 1'b1, 1'b1, 1'b0, 32'h0000_005A));
    exp_q.push_back(mk(n + 2, K_BUS, 1'b1, 1'b0, 1'b0, 32'h1));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      wait_obs(ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL rst_tx_event: got nothing, required cyc=%0d", e.cyc);
      end else begin
        o = obs[rd];
        rd++;
        if (o !== e) begin
          errors++;
          $display("FAIL rst_tx_event: got cyc=%0d wr=%b sel=%b addr=%b data=%h, required cyc=%0d wr=%b sel=%b addr=%b data=%h",
                   o.cyc, o.wr, o.sel, o.addr, o.data, e.cyc, e.wr, e.sel, e.addr, e.data);
        end
      end
    end
    for (int i = 0; i < 20 && cyc < n + 10; i++) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (tx_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_ready_in_reset: got %b required 0", tx_ready_o);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({wr_o, reg_sel_o, addr_o, data_o, tx_done_o, rx_valid_o, rx_data_o, err_o} !== '0) begin
      errors++;
      $display("FAIL rst_outputs: got wr=%b sel=%b addr=%b data=%h done=%b rxv=%b rxd=%h err=%b, required all 0",
               wr_o, reg_sel_o, addr_o, data_o, tx_done_o, rx_valid_o, rx_data_o, err_o);
    end
    checks++;
    if (tx_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_idle_ready: got %b required 1", tx_ready_o);
    end
    repeat (60) @(negedge clk);
    #3;
    checks++;
    if (obs_n !== rd) begin
      errors++;
      $display("FAIL rst_no_done: got %0d events after reset required 0", obs_n - rd);
      rd = obs_n;
    end
    checks++;
    if (viol !== 0) begin
      errors++;
      $display("FAIL bus_rules: got %0d cycles with data_o!=0 while idle or tx_ready outside IDLE, required 0", viol);
    end
  endtask

  task automatic test_timeout();
    int n, c, dw_c, cw_c, idle_c, err_c;
    bit done_seen;
    @(negedge clk);
    tx_data2  = 8'h96;
    tx_valid2 = 1'b1;
    n = -1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (ready2) begin
        n = cyc;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    tx_valid2 = 1'b0;
    dw_c = -1; cw_c = -1; idle_c = -1; err_c = -1; done_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #2;
      c = cyc;
      if (wr2 && sel2 && !addr2 && data2 == 32'h96 && dw_c < 0) dw_c = c;
      if (wr2 && !sel2 && data2 == 32'h1 && cw_c < 0) cw_c = c;
      if (c > n && ready2 && idle_c < 0) idle_c = c;
      if (err2 && err_c < 0) err_c = c;
      if (done2) done_seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (n < 0 || dw_c !== n + 1 || cw_c !== n + 2) begin
      errors++;
      $display("FAIL tmo_writes: got handshake=%0d data_wr=%0d ctrl_wr=%0d required n, n+1, n+2", n, dw_c, cw_c);
    end
    checks++;
    if (idle_c !== n + 19) begin
      errors++;
      $display("FAIL tmo_return_idle: got cycle %0d required %0d", idle_c, n + 19);
    end
    checks++;
    if (err_c !== n + 19) begin
      errors++;
      $display("FAIL tmo_err_set: got cycle %0d required %0d", err_c, n + 19);
    end
    checks++;
    if (done_seen !== 1'b0) begin
      errors++;
      $display("FAIL tmo_no_done: got tx_done=%b required 0", done_seen);
    end
    repeat (20) @(negedge clk);
    #1;
    checks++;
    if (err2 !== 1'b1) begin
      errors++;
      $display("FAIL tmo_err_sticky: got %b required 1", err2);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (err2 !== 1'b0) begin
      errors++;
      $display("FAIL tmo_err_reset: got %b required 0", err2);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion by 1 ms, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_tx();
    test_rx();
    test_rx_backpressure();
    test_simultaneous();
    test_reset_mid_tx();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/module_uart_host_ctrl.md
MODULE_UART_HOST_CTRL -- requirements
Module: module_uart_host_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 20000, is the maximum number of cycles spent in TX_WAIT before the block aborts.
REQ-002 clk_i  input  1  single clock for all logic.
REQ-003 rst_i  input  1  reset; synchronous, active-high.
REQ-004 tx_data_i  input  8  byte to transmit.
REQ-005 tx_valid_i  input  1  client offers tx_data_i.
REQ-006 tx_ready_o  output  1  block accepts the byte this cycle.
REQ-007 tx_done_o  output  1  one-cycle pulse when the peripheral finishes sending.
REQ-008 rx_data_o  output  8  held received byte.
REQ-009 rx_valid_o  output  1  rx_data_o is valid.
REQ-010 rx_ready_i  input  1  client consumes rx_data_o.
REQ-011 err_o  output  1  sticky TX timeout flag.
REQ-012 wr_o  output  1  peripheral register write strobe.
REQ-013 reg_sel_o  output  1  peripheral register select: 0 = control, 1 = data.
REQ-014 addr_o  output  1  data register address: 0 = TX byte, 1 = RX byte.
REQ-015 data_o  output  32  peripheral write data.
REQ-016 data_i  input  32  peripheral combinational read data, sampled at the clock edge ending the cycle that presents reg_sel_o/addr_o.

Function
REQ-017 Control register bits: bit0 SEND is set by the host and cleared by the peripheral when transmission completes; bit1 NEW_RX is set by the peripheral and cleared by the host writing 0.
REQ-018 The block SHALL implement the FSM states IDLE, TX_WR_DATA, TX_WR_CTRL, TX_WAIT, RX_RD_DATA and RX_CLR_CTRL.
REQ-019 IDLE: wr_o=0, reg_sel_o=0; every cycle it reads the control register.
REQ-020 IDLE transitions:
  - data_i[1]=1 and rx_valid_o=0 -> RX_RD_DATA (RX has priority over TX);
  - otherwise, tx_valid_i=1 -> TX_WR_DATA.
REQ-021 tx_ready_o=1 only in IDLE when the RX branch is not taken; the byte is captured on tx_valid_i & tx_ready_o.
REQ-022 TX_WR_DATA: one cycle with wr_o=1, reg_sel_o=1, addr_o=0, data_o={24'b0, captured byte}; then -> TX_WR_CTRL.
REQ-023 TX_WR_CTRL: one cycle with wr_o=1, reg_sel_o=0, data_o=32'h1; clears the timeout counter; then -> TX_WAIT.
REQ-024 TX_WAIT: wr_o=0, reg_sel_o=0; the timeout counter increments each cycle.
  - data_i[0]=0 -> IDLE with tx_done_o pulsed for one cycle.
  - Counter reaches TIMEOUT_CYCLES-1 with data_i[0] still 1 -> IDLE, err_o set, no tx_done_o.
REQ-025 RX_RD_DATA: one cycle with wr_o=0, reg_sel_o=1, addr_o=1; rx_data_o<=data_i[7:0] and rx_valid_o<=1; then -> RX_CLR_CTRL.
REQ-026 RX_CLR_CTRL: one cycle with wr_o=1, reg_sel_o=0, data_o=32'h0; then -> IDLE.
REQ-027 rx_valid_o clears on rx_valid_o & rx_ready_i.
  - While rx_valid_o=1, NEW_RX is not serviced and the peripheral holds the byte.
  - Consume and a new RX capture in the same cycle cannot occur, because RX_RD_DATA requires rx_valid_o=0 on entry.
REQ-028 TX latency: handshake cycle N; data write N+1; control write N+2; TX_WAIT from N+3.
REQ-029 Throughput: at most one TX byte is outstanding; tx_ready_o=0 in all states except IDLE.
REQ-030 When TX and RX are both pending in IDLE, the RX path completes first (3 cycles) before TX is accepted.
REQ-031 Timeout counter width SHALL be $clog2(TIMEOUT_CYCLES); no wrap-around is possible within TX_WAIT.
REQ-032 err_o clears only on reset.
REQ-033 When wr_o=0, data_o SHALL be 32'h0.

Reset
REQ-034 With rst_i=1 at a clock edge, the block SHALL enter IDLE from any state, including mid-TX or mid-RX.
REQ-035 Reset values: wr_o=0, reg_sel_o=0, addr_o=0, data_o=0, tx_ready_o=0 in the reset cycle, tx_done_o=0, rx_valid_o=0, rx_data_o=0, err_o=0, timeout counter=0.
REQ-036 A TX byte accepted before a mid-operation reset is discarded with no tx_done_o.

Structure
REQ-037 pkg_UART SHALL hold:
  - the FSM state enum;
  - control bit indices SEND=0 and NEW_RX=1;
  - REG_SEL_CONTROL=0 and REG_SEL_DATA=1;
  - ADDR_TX=0 and ADDR_RX=1.
REQ-038 The timeout counter SHALL be a sub-module module_timeout_counter (clear, enable, terminal-count output); all other logic is flat in the block.

Verification
REQ-039 Scenario TX: tx_data_i=8'hA5, tx_valid_i=1; the model clears SEND 50 cycles after the control write.
  - Expect data write 32'h000000A5 at N+1 and control write 32'h1 at N+2.
  - Expect a single tx_done_o 50 cycles after the control write.
REQ-040 Scenario RX: model sets NEW_RX with the RX byte 8'h3C.
  - Expect a data read at addr 1, rx_data_o=8'h3C with rx_valid_o=1, then a control write 32'h0.
REQ-041 Scenario RX backpressure: hold rx_ready_i=0, deliver 8'h11, then raise NEW_RX again with 8'h22.
  - Expect no addr-1 read until rx_ready_i=1; then 8'h22 is delivered.
REQ-042 Scenario simultaneous: NEW_RX=1 and tx_valid_i=1 in the same IDLE cycle.
  - Expect the RX sequence first and tx_ready_o=0 for 3 cycles, then the TX handshake.
REQ-043 Scenario timeout: TIMEOUT_CYCLES=16 and SEND never clears.
  - Expect a return to IDLE 16 cycles after entering TX_WAIT, err_o=1 sticky, no tx_done_o.
REQ-044 Scenario reset mid-TX: assert rst_i during TX_WAIT.
  - Expect the next cycle IDLE with all outputs at reset values, and no tx_done_o.
